if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: circular FREE/PENDING/READY slot queue between PC register, instruction memory and decode.
// Latency: a response accepted in cycle N reaches the decode channel in cycle N+1 (never bypassed).
// Backpressure: pc_ready drops on a busy tail slot, flush or DEPTH outstanding fetches; responses are never stalled.
// Build option: define IF_FETCH_QUEUE_MISALIGN_CHK_EN to keep a per-slot misaligned-PC flag on inst_misalign.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            flush,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            inst_misalign
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_PEND  = 2'd1,
        S_READY = 2'd2
    } slot_e;

    slot_e           state_q [DEPTH];
    slot_e           state_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     data_q  [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   rsp_q, rsp_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   pend_cnt;
    logic [OW-1:0]   outstanding;
    logic            slot_free;
    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            pop;

    // Count slots still waiting for their memory response
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == S_PEND) pend_cnt = pend_cnt + CW'(1);
        end
    end

    // Responses still owed by memory: live pending slots plus those a flush orphaned.
    // Capping this at DEPTH keeps the discard counter inside its width across back-to-back flushes.
    assign outstanding = {1'b0, disc_q} + {1'b0, pend_cnt};
    assign slot_free   = (state_q[tail_q] == S_FREE) && (outstanding < OW'(DEPTH));

    // rst gates the request side so both handshake outputs are low throughout reset
    assign imem_req_valid = rst & pc_valid & slot_free & ~flush;
    assign pc_ready       = rst & imem_req_ready & slot_free & ~flush;
    assign imem_req_addr  = pc_in;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_take = imem_rsp_valid && (disc_q == '0) && (state_q[rsp_q] == S_PEND);
    assign rsp_drop = imem_rsp_valid && (disc_q != '0);

    assign inst_valid = (state_q[head_q] == S_READY);
    assign inst_data  = data_q[head_q];
    assign inst_pc    = pc_q[head_q];
    assign pop        = inst_valid & inst_ready;

    // Next-state for slot states, pointers and discard counter; flush overrides all other events
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rsp_d   = rsp_q;
        disc_d  = disc_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) state_d[i] = S_FREE;
            head_d = '0;
            tail_d = '0;
            rsp_d  = '0;
            disc_d = CW'(outstanding - OW'(rsp_take | rsp_drop));
        end else begin
            if (req_fire) begin
                state_d[tail_q] = S_PEND;
                tail_d          = tail_q + PW'(1);
            end
            if (rsp_take) begin
                state_d[rsp_q] = S_READY;
                rsp_d          = rsp_q + PW'(1);
            end
            if (rsp_drop) disc_d = disc_q - CW'(1);
            if (pop) begin
                state_d[head_q] = S_FREE;
                head_d          = head_q + PW'(1);
            end
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= S_FREE;
            head_q <= '0;
            tail_q <= '0;
            rsp_q  <= '0;
            disc_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rsp_q   <= rsp_d;
            disc_q  <= disc_d;
        end
    end

    // Payload storage: PC at allocation, instruction word on response (qualified by slot state)
    always_ff @(posedge clk) begin
        if (req_fire) pc_q[tail_q] <= pc_in;
        if (rsp_take) data_q[rsp_q] <= imem_rsp_data;
    end

`ifdef IF_FETCH_QUEUE_MISALIGN_CHK_EN
    logic mis_q [DEPTH];

    // Record whether each allocated PC is off a 4-byte boundary
    always_ff @(posedge clk) begin
        if (req_fire) mis_q[tail_q] <= (pc_in[1:0] != 2'b00);
    end

    assign inst_misalign = inst_valid & mis_q[head_q];
`else
    assign inst_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: table of request-gating vectors plus scenario sequences for if_fetch_queue.
// A 1-cycle in-order memory model answers requests; a scoreboard queue holds expected {pc, data}.
// Each decode pop is compared against the scoreboard head; flush empties the scoreboard.
module tb_if_fetch_queue;
    localparam int XLEN = 64;

`ifdef IF_FETCH_QUEUE_MISALIGN_CHK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            flush;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            inst_misalign;

    if_fetch_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .inst_misalign  (inst_misalign)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        pv;
        logic        rr;
        logic        fl;
        logic [63:0] pc;
        logic        exp_rv;
        logic        exp_pr;
    } vec_t;

    exp_t        sb [$];
    logic [63:0] mem_q [$];
    logic        mem_en;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] memf(logic [63:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive this cycle's memory response, settle, then run monitor and scoreboard
    task automatic pre();
        exp_t e;
        if (mem_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_data", {32'd0, inst_data}, {32'd0, e.data});
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            sb.push_back('{pc: pc_in, data: memf(pc_in)});
        end
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (flush) sb.delete();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        pc_valid   = 1'b0;
        inst_ready = 1'b1;
        mem_en     = 1'b1;
        while ((sb.size() != 0 || mem_q.size() != 0) && n < 40) begin
            pre();
            post();
            n++;
        end
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
        pre();
        chk({name, "_empty_after_drain"}, {63'd0, inst_valid}, 64'd0);
        post();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        tbl[0] = '{pv:1'b0, rr:1'b0, fl:1'b0, pc:64'h1000, exp_rv:1'b0, exp_pr:1'b0};
        tbl[1] = '{pv:1'b0, rr:1'b1, fl:1'b0, pc:64'h1004, exp_rv:1'b0, exp_pr:1'b1};
        tbl[2] = '{pv:1'b1, rr:1'b0, fl:1'b0, pc:64'h1008, exp_rv:1'b1, exp_pr:1'b0};
        tbl[3] = '{pv:1'b1, rr:1'b1, fl:1'b0, pc:64'h100C, exp_rv:1'b1, exp_pr:1'b1};
        tbl[4] = '{pv:1'b0, rr:1'b0, fl:1'b1, pc:64'h2000, exp_rv:1'b0, exp_pr:1'b0};
        tbl[5] = '{pv:1'b0, rr:1'b1, fl:1'b1, pc:64'h2004, exp_rv:1'b0, exp_pr:1'b0};
        tbl[6] = '{pv:1'b1, rr:1'b0, fl:1'b1, pc:64'h2008, exp_rv:1'b0, exp_pr:1'b0};
        tbl[7] = '{pv:1'b1, rr:1'b1, fl:1'b1, pc:64'hDEAD_BEEF_0000_0010, exp_rv:1'b0, exp_pr:1'b0};

        rst = 1'b1; pc_in = '0; pc_valid = 1'b1; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; flush = 1'b0; inst_ready = 1'b1; mem_en = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("reset_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("reset_pc_ready", {63'd0, pc_ready}, 64'd0);
        chk("reset_misalign", {63'd0, inst_misalign}, 64'd0);
        pc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Request gating on an empty queue; no clock edge is crossed inside the table
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            pc_valid = tbl[i].pv; imem_req_ready = tbl[i].rr; flush = tbl[i].fl; pc_in = tbl[i].pc;
            #1;
            chk($sformatf("vec%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, tbl[i].exp_rv});
            chk($sformatf("vec%0d_pc_ready", i), {63'd0, pc_ready}, {63'd0, tbl[i].exp_pr});
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].pc);
        end
        pc_valid = 1'b0; flush = 1'b0; imem_req_ready = 1'b1;
        post();

        // Basic: 0x0, 0x4, 0x8 with 1-cycle memory
        inst_ready = 1'b1; mem_en = 1'b1; pc_valid = 1'b1;
        pc_in = 64'h0; pre(); chk("basic_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("basic_pc_ready", {63'd0, pc_ready}, 64'd1); post();
        pc_in = 64'h4; pre(); chk("basic_no_bypass", {63'd0, inst_valid}, 64'd0); post();
        pc_in = 64'h8; pre(); chk("basic_i0_valid", {63'd0, inst_valid}, 64'd1);
        chk("basic_i0_pc", inst_pc, 64'h0); post();
        pc_valid = 1'b0; pre(); chk("basic_i1_pc", inst_pc, 64'h4); post();
        pre(); chk("basic_i2_pc", inst_pc, 64'h8); post();
        pre(); chk("basic_empty", {63'd0, inst_valid}, 64'd0); post();

        // Full: four accepted, fifth refused, same-cycle pop does not help, next cycle does
        inst_ready = 1'b0; pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in = 64'h10 + 64'(4 * i);
            pre(); chk($sformatf("full_accept%0d", i), {63'd0, pc_ready}, 64'd1); post();
        end
        pc_in = 64'h20;
        pre(); chk("full_5th_pc_ready", {63'd0, pc_ready}, 64'd0);
        chk("full_5th_req_valid", {63'd0, imem_req_valid}, 64'd0); post();
        pre(); post();
        inst_ready = 1'b1; pre(); chk("full_pop_same_cycle", {63'd0, pc_ready}, 64'd0); post();
        inst_ready = 1'b0; pre(); chk("full_after_pop", {63'd0, pc_ready}, 64'd1); post();
        drain("full");

        // Flush with one READY and two PENDING slots
        inst_ready = 1'b0; pc_valid = 1'b1;
        mem_en = 1'b0; pc_in = 64'h40; pre(); post();
        mem_en = 1'b1; pc_in = 64'h44; pre(); post();
        mem_en = 1'b0; pc_in = 64'h48; pre(); post();
        pc_in = 64'h100; flush = 1'b1;
        pre(); chk("flush_head_ready", {63'd0, inst_valid}, 64'd1);
        chk("flush_no_req", {63'd0, imem_req_valid}, 64'd0);
        chk("flush_pc_ready", {63'd0, pc_ready}, 64'd0); post();
        flush = 1'b0; pc_valid = 1'b0;
        pre(); chk("flush_inst_valid_next", {63'd0, inst_valid}, 64'd0); post();
        mem_en = 1'b1; inst_ready = 1'b1; pc_valid = 1'b1; pc_in = 64'h100;
        pre(); chk("flush_new_req", {63'd0, imem_req_valid}, 64'd1); post();
        pc_valid = 1'b0;
        pre(); chk("flush_drop1", {63'd0, inst_valid}, 64'd0); post();
        pre(); chk("flush_drop2", {63'd0, inst_valid}, 64'd0); post();
        pre(); chk("flush_new_valid", {63'd0, inst_valid}, 64'd1);
        chk("flush_new_pc", inst_pc, 64'h100); post();
        drain("flush");

        // Simultaneous request, response and pop with two entries queued
        inst_ready = 1'b0; pc_valid = 1'b1;
        mem_en = 1'b0; pc_in = 64'h200; pre(); post();
        mem_en = 1'b1; pc_in = 64'h204; pre(); post();
        pc_in = 64'h208; inst_ready = 1'b1;
        pre(); chk("sim_pop_valid", {63'd0, inst_valid}, 64'd1);
        chk("sim_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("sim_head_pc", inst_pc, 64'h200); post();
        pc_valid = 1'b0;
        pre(); chk("sim_next_valid", {63'd0, inst_valid}, 64'd1);
        chk("sim_next_pc", inst_pc, 64'h204); post();
        pre(); chk("sim_last_valid", {63'd0, inst_valid}, 64'd1);
        chk("sim_last_pc", inst_pc, 64'h208); post();
        pre(); chk("sim_empty", {63'd0, inst_valid}, 64'd0); post();

        // Misaligned PC followed by an aligned one
        inst_ready = 1'b0; mem_en = 1'b1; pc_valid = 1'b1;
        pc_in = 64'h6; pre(); post();
        pc_in = 64'h8; pre(); post();
        pc_valid = 1'b0; inst_ready = 1'b1;
        pre(); chk("mis_pc", inst_pc, 64'h6);
        chk("mis_flag", {63'd0, inst_misalign}, {63'd0, MIS_EXP}); post();
        pre(); chk("mis_aligned_pc", inst_pc, 64'h8);
        chk("mis_aligned_flag", {63'd0, inst_misalign}, 64'd0); post();
        drain("mis");

        // Reset asserted mid-stream; outputs must drop before the next edge
        inst_ready = 1'b0; pc_valid = 1'b1;
        mem_en = 1'b0; pc_in = 64'h306; pre(); post();
        mem_en = 1'b1; pc_in = 64'h304; pre(); post();
        mem_en = 1'b0; pc_in = 64'h308;
        pre(); chk("rst_pre_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("rst_pre_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rst_pre_misalign", {63'd0, inst_misalign}, {63'd0, MIS_EXP});
        rst = 1'b0;
        #1;
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_pc_ready", {63'd0, pc_ready}, 64'd0);
        chk("rst_misalign", {63'd0, inst_misalign}, 64'd0);
        mem_q.delete(); sb.delete(); pc_valid = 1'b0;
        post();
        rst = 1'b1;
        inst_ready = 1'b1; mem_en = 1'b1; pc_valid = 1'b1; pc_in = 64'h400;
        pre(); chk("post_rst_req", {63'd0, imem_req_valid}, 64'd1); post();
        pc_valid = 1'b0;
        pre(); chk("post_rst_no_stale", {63'd0, inst_valid}, 64'd0); post();
        pre(); chk("post_rst_valid", {63'd0, inst_valid}, 64'd1);
        chk("post_rst_pc", inst_pc, 64'h400); post();
        drain("post_rst");

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
